pointer_memory: RTL and testbench
=================================

POINTER_MEMORY -- requirements
Module: pointer_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: pointer width; cell array depth is 2^(ADDR_WIDTH+1) words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word and bus width.
REQ-003 SHALL have parameter NUM_PTRS, default 3: number of address pointers (0 MAR, 1 PC, 2 SP).
REQ-004 SHALL have port clock  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in  input  DATA_WIDTH  write data or pointer operand.
REQ-007 SHALL have port out  output  DATA_WIDTH  registered read data.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse marking new read data on out.
REQ-009 SHALL have port word_sel  input  1  low address bit appended below the pointer.
REQ-010 SHALL have port ptr_sel  input  max(1,$clog2(NUM_PTRS))  selects the active pointer.
REQ-011 SHALL have port op  input  memory_op_e  operation for this cycle.
REQ-012 SHALL have port ptr_out  output  ADDR_WIDTH  combinational value of the selected pointer.
REQ-013 SHALL have port fault  output  1  sticky pointer-wrap flag.

Function
REQ-014 SHALL form the cell address as {pointer[ptr_sel], word_sel}.
REQ-015 SHALL execute exactly one op per cycle on the selected pointer only; other pointers hold.
REQ-016 NOP SHALL change no state; out holds its previous value.
REQ-017 READ SHALL register cells[addr] onto out at the edge, out_valid high for the following cycle only (latency 1).
REQ-018 WRITE SHALL store in to cells[addr] at the edge.
REQ-019 LOAD SHALL set the pointer to in, zero-extended or truncated to ADDR_WIDTH.
REQ-020 REL_ADD and REL_SUB SHALL add/subtract in (zero-extended/truncated as REQ-019) modulo 2^ADDR_WIDTH.
REQ-021 INC and DEC SHALL add/subtract 1 modulo 2^ADDR_WIDTH.
REQ-022 READ_POSTINC SHALL read at the old pointer value and increment the pointer in the same cycle.
REQ-023 WRITE_PREDEC SHALL decrement the pointer and write in at the decremented address in the same cycle.
REQ-024 A READ at an address written in the previous cycle SHALL return the new data.
REQ-025 ptr_sel >= NUM_PTRS SHALL be treated as NOP, with ptr_out reading zero.
REQ-026 out_valid SHALL be low in any cycle not following a READ or READ_POSTINC.

Reset
REQ-027 On reset low, all pointers, out, out_valid and fault SHALL clear to 0 immediately, independent of clock.
REQ-028 A read issued in the cycle reset asserts SHALL be discarded; out_valid stays 0.
REQ-029 Cell contents SHALL NOT be reset.

Configuration
REQ-030 With MEMORY_WRAP_FAULT_EN defined, fault SHALL set on any pointer update that carries/borrows past 2^ADDR_WIDTH and stay set until reset; the pointer still wraps.
REQ-031 Without MEMORY_WRAP_FAULT_EN, fault SHALL be tied 0 and no detection logic built.

Structure
REQ-032 memory_op_e (NOP, READ, WRITE, LOAD, REL_ADD, REL_SUB, INC, DEC, READ_POSTINC, WRITE_PREDEC) and constants PTR_MAR=0, PTR_PC=1, PTR_SP=2 SHALL live in package control.
REQ-033 Pointer registers, update arithmetic and wrap detection SHALL be one sub-module, memory_pointer_file; the cell array and read register stay in pointer_memory.

Verification
REQ-034 Reset release, LOAD ptr0=0x10, WRITE 0xA5 word_sel=0, READ -> out=0xA5 with out_valid one cycle later, pulse width 1.
REQ-035 LOAD ptr1=0xFF, INC -> ptr_out=0x00; fault=1 with MEMORY_WRAP_FAULT_EN, 0 without; ptr0 unchanged.
REQ-036 LOAD ptr2=0x80, WRITE_PREDEC 0x11, WRITE_PREDEC 0x22, READ_POSTINC twice -> out 0x22 then 0x11, ptr2 back to 0x80.
REQ-037 LOAD ptr0=0x05, REL_SUB 0x07 -> ptr_out=0xFE, fault set (EN build); REL_ADD 0x02 -> 0x00.
REQ-038 Issue READ, assert reset mid-cycle before the edge -> out=0, out_valid=0, all pointers 0, memory data retained on later READ.
REQ-039 WRITE 0x3C then READ same address back-to-back; ptr_sel=3 with op=INC -> out=0x3C, no pointer changes.

Source files
------------

// File: rtl/pointer_memory_pkg.sv
// Shared definitions for the pointer memory: the operation encoding, the
// well-known pointer indices and small op-classification helpers.
// Optional build macro used elsewhere: MEMORY_WRAP_FAULT_EN.
package control;

    // One operation is executed per clock on the selected pointer.
    typedef enum logic [3:0] {
        NOP          = 4'd0,
        READ         = 4'd1,
        WRITE        = 4'd2,
        LOAD         = 4'd3,
        REL_ADD      = 4'd4,
        REL_SUB      = 4'd5,
        INC          = 4'd6,
        DEC          = 4'd7,
        READ_POSTINC = 4'd8,
        WRITE_PREDEC = 4'd9
    } memory_op_e;

    // Conventional roles of the pointer slots.
    localparam int PTR_MAR = 0;
    localparam int PTR_PC  = 1;
    localparam int PTR_SP  = 2;

    // Ops that load the read register and raise out_valid next cycle.
    function automatic logic op_is_read(input memory_op_e op);
        return (op == READ) || (op == READ_POSTINC);
    endfunction

    // Ops that store the data input into the cell array.
    function automatic logic op_is_write(input memory_op_e op);
        return (op == WRITE) || (op == WRITE_PREDEC);
    endfunction

endpackage

// File: rtl/memory_pointer_file.sv
// Pointer register file: holds NUM_PTRS address pointers, computes the
// update for the selected one and supplies the address used for the access.
// Build macro: MEMORY_WRAP_FAULT_EN adds a sticky carry/borrow detector;
// without it fault_o is a constant 0 and no detection logic exists.
module memory_pointer_file
    import control::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PTRS   = 3,
    parameter int SEL_WIDTH  = (NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  memory_op_e            op_i,
    input  logic [SEL_WIDTH-1:0]  ptr_sel_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    output logic [ADDR_WIDTH-1:0] ptr_o,
    output logic [ADDR_WIDTH-1:0] access_ptr_o,
    output logic                  sel_valid_o,
    output logic                  fault_o
);

    logic [ADDR_WIDTH-1:0] ptr_vals [NUM_PTRS];
    logic [ADDR_WIDTH-1:0] cur_ptr;
    logic [ADDR_WIDTH-1:0] operand;
    logic [ADDR_WIDTH-1:0] delta;
    logic [ADDR_WIDTH-1:0] arith_res;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic                  sel_valid;
    logic                  ptr_we;
    logic                  ptr_commit;
    logic                  is_arith;
    logic                  is_sub;

    // Operand is zero-extended or truncated to pointer width.
    assign operand = ADDR_WIDTH'(operand_i);

    // Select the active pointer; an out-of-range selector reads as zero.
    always_comb begin
        cur_ptr   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_PTRS; i++) begin
            if (ptr_sel_i == SEL_WIDTH'(i)) begin
                cur_ptr   = ptr_vals[i];
                sel_valid = 1'b1;
            end
        end
    end

    // Decode the op into a pointer write enable and an add/sub amount.
    always_comb begin
        ptr_we   = 1'b0;
        is_arith = 1'b0;
        is_sub   = 1'b0;
        delta    = '0;
        case (op_i)
            LOAD: begin
                ptr_we = 1'b1;
            end
            REL_ADD: begin
                ptr_we   = 1'b1;
                is_arith = 1'b1;
                delta    = operand;
            end
            REL_SUB: begin
                ptr_we   = 1'b1;
                is_arith = 1'b1;
                is_sub   = 1'b1;
                delta    = operand;
            end
            INC, READ_POSTINC: begin
                ptr_we   = 1'b1;
                is_arith = 1'b1;
                delta    = ADDR_WIDTH'(1);
            end
            DEC, WRITE_PREDEC: begin
                ptr_we   = 1'b1;
                is_arith = 1'b1;
                is_sub   = 1'b1;
                delta    = ADDR_WIDTH'(1);
            end
            default: begin
            end
        endcase
    end

`ifdef MEMORY_WRAP_FAULT_EN
    logic [ADDR_WIDTH:0] arith_ext;
    logic                wrap;
    logic                fault_q;

    // One extra bit captures carry out of an add or borrow out of a subtract.
    always_comb begin
        if (is_sub) begin
            arith_ext = {1'b0, cur_ptr} - {1'b0, delta};
        end else begin
            arith_ext = {1'b0, cur_ptr} + {1'b0, delta};
        end
    end

    assign arith_res = arith_ext[ADDR_WIDTH-1:0];
    assign wrap      = is_arith & sel_valid & arith_ext[ADDR_WIDTH];

    // Sticky wrap flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
        end else if (wrap) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    assign arith_res = is_sub ? (cur_ptr - delta) : (cur_ptr + delta);
    assign fault_o   = 1'b0;
`endif

    assign ptr_d      = is_arith ? arith_res : operand;
    assign ptr_commit = ptr_we & sel_valid;

    // Each pointer updates only when it is the selected one.
    generate
        for (genvar gi = 0; gi < NUM_PTRS; gi++) begin : gen_ptr
            logic [ADDR_WIDTH-1:0] ptr_q;

            // Pointer register gi: load or modular update when selected.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ptr_q <= '0;
                end else if (ptr_commit && (ptr_sel_i == SEL_WIDTH'(gi))) begin
                    ptr_q <= ptr_d;
                end
            end

            assign ptr_vals[gi] = ptr_q;
        end
    endgenerate

    // Pre-decrement writes use the decremented pointer; all else the current one.
    assign access_ptr_o = (op_i == WRITE_PREDEC) ? arith_res : cur_ptr;
    assign ptr_o        = cur_ptr;
    assign sel_valid_o  = sel_valid;

endmodule

// File: rtl/pointer_memory.sv
// Pointer-addressed word memory. The cell address is the selected pointer
// with word_sel appended as the low bit. Reads are registered (latency 1)
// with a one-cycle out_valid pulse; cell contents are never reset.
// Build macro: MEMORY_WRAP_FAULT_EN enables the sticky pointer-wrap fault.
module pointer_memory
    import control::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PTRS   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  word_sel,
    input  logic [((NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1)-1:0] ptr_sel,
    input  memory_op_e            op,
    output logic [ADDR_WIDTH-1:0] ptr_out,
    output logic                  fault
);

    localparam int SEL_WIDTH = (NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1;
    localparam int DEPTH     = 2 ** (ADDR_WIDTH + 1);

    logic [DATA_WIDTH-1:0] cells [DEPTH];
    logic [ADDR_WIDTH-1:0] access_ptr;
    logic [ADDR_WIDTH:0]   addr;
    logic                  sel_valid;
    logic                  do_read;
    logic                  do_write;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic                  out_valid_q;
    logic                  out_valid_d;

    memory_pointer_file #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PTRS   (NUM_PTRS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_ptr_file (
        .clk_i        (clock),
        .rst_ni       (reset),
        .op_i         (op),
        .ptr_sel_i    (ptr_sel),
        .operand_i    (in),
        .ptr_o        (ptr_out),
        .access_ptr_o (access_ptr),
        .sel_valid_o  (sel_valid),
        .fault_o      (fault)
    );

    assign addr     = {access_ptr, word_sel};
    // An invalid pointer selector turns every op into a NOP.
    assign do_read  = sel_valid & op_is_read(op);
    assign do_write = sel_valid & op_is_write(op);

    // Cell array write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (do_write) begin
            cells[addr] <= in;
        end
    end

    // Next read-register value: new data on a read, otherwise hold.
    always_comb begin
        out_d       = out_q;
        out_valid_d = do_read;
        if (do_read) begin
            out_d = cells[addr];
        end
    end

    // Registered read data and its valid pulse, cleared at once by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pointer_memory.sv
// Directed test of pointer_memory with hand-computed expectations.
module tb_pointer_memory;
    import control::*;

`ifdef MEMORY_WRAP_FAULT_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] in;
    logic [7:0] out;
    logic       out_valid;
    logic       word_sel;
    logic [1:0] ptr_sel;
    memory_op_e op;
    logic [7:0] ptr_out;
    logic       fault;

    int checks_total;
    int checks_passed;

    pointer_memory #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .NUM_PTRS   (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .word_sel  (word_sel),
        .ptr_sel   (ptr_sel),
        .op        (op),
        .ptr_out   (ptr_out),
        .fault     (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one op, let one edge pass, settle 1 time unit after it.
    task automatic do_op(input memory_op_e o, input logic [1:0] s, input logic ws, input logic [7:0] d);
        op       = o;
        ptr_sel  = s;
        word_sel = ws;
        in       = d;
        @(posedge clock);
        #1;
    endtask

    // Look at a pointer combinationally without clocking.
    task automatic peek(input logic [1:0] s);
        op      = NOP;
        ptr_sel = s;
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset    = 1'b0;
        op       = NOP;
        ptr_sel  = 2'd0;
        word_sel = 1'b0;
        in       = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out", out, 8'h00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ptr", ptr_out, 8'h00);
        check("rst_fault", fault, 1'b0);
        reset = 1'b1;

        // Basic load / write / read with one-cycle valid pulse.
        do_op(LOAD, 2'd0, 1'b0, 8'h10);
        check("load_p0", ptr_out, 8'h10);
        do_op(WRITE, 2'd0, 1'b0, 8'hA5);
        check("wr_novalid", out_valid, 1'b0);
        do_op(READ, 2'd0, 1'b0, 8'h00);
        check("rd_out", out, 8'hA5);
        check("rd_valid", out_valid, 1'b1);
        do_op(NOP, 2'd0, 1'b0, 8'h00);
        check("pulse_end", out_valid, 1'b0);
        check("nop_hold", out, 8'hA5);

        // Increment wrap on PC.
        do_op(LOAD, 2'd1, 1'b0, 8'hFF);
        do_op(INC, 2'd1, 1'b0, 8'h00);
        check("inc_wrap", ptr_out, 8'h00);
        check("inc_fault", fault, FAULT_EN);
        peek(2'd0);
        check("p0_hold", ptr_out, 8'h10);

        // Stack push/pop on SP.
        do_op(LOAD, 2'd2, 1'b0, 8'h80);
        do_op(WRITE_PREDEC, 2'd2, 1'b0, 8'h11);
        check("predec1", ptr_out, 8'h7F);
        do_op(WRITE_PREDEC, 2'd2, 1'b0, 8'h22);
        check("predec2", ptr_out, 8'h7E);
        do_op(READ_POSTINC, 2'd2, 1'b0, 8'h00);
        check("pop1_out", out, 8'h22);
        check("pop1_valid", out_valid, 1'b1);
        check("pop1_ptr", ptr_out, 8'h7F);
        do_op(READ_POSTINC, 2'd2, 1'b0, 8'h00);
        check("pop2_out", out, 8'h11);
        check("pop2_valid", out_valid, 1'b1);
        check("pop2_ptr", ptr_out, 8'h80);

        // Relative arithmetic with borrow and carry.
        do_op(LOAD, 2'd0, 1'b0, 8'h05);
        do_op(REL_SUB, 2'd0, 1'b0, 8'h07);
        check("relsub", ptr_out, 8'hFE);
        check("relsub_flt", fault, FAULT_EN);
        do_op(REL_ADD, 2'd0, 1'b0, 8'h02);
        check("reladd", ptr_out, 8'h00);
        do_op(DEC, 2'd0, 1'b0, 8'h00);
        check("dec_wrap", ptr_out, 8'hFF);
        do_op(INC, 2'd0, 1'b0, 8'h00);
        check("inc_back", ptr_out, 8'h00);

        // Write then read back-to-back, then an invalid selector.
        do_op(WRITE, 2'd0, 1'b1, 8'h3C);
        do_op(READ, 2'd0, 1'b1, 8'h00);
        check("raw_out", out, 8'h3C);
        check("raw_valid", out_valid, 1'b1);
        do_op(INC, 2'd3, 1'b1, 8'h00);
        check("bad_out", out, 8'h3C);
        check("bad_valid", out_valid, 1'b0);
        check("bad_ptrout", ptr_out, 8'h00);
        do_op(WRITE, 2'd3, 1'b1, 8'h99);
        do_op(READ, 2'd3, 1'b1, 8'h00);
        check("bad_rd_valid", out_valid, 1'b0);
        peek(2'd0);
        check("bad_p0", ptr_out, 8'h00);
        peek(2'd1);
        check("bad_p1", ptr_out, 8'h00);
        peek(2'd2);
        check("bad_p2", ptr_out, 8'h80);
        do_op(READ, 2'd0, 1'b1, 8'h00);
        check("bad_nowrite", out, 8'h3C);

        // Reset asserted mid-cycle while a read is pending.
        do_op(LOAD, 2'd0, 1'b0, 8'h10);
        op       = READ;
        ptr_sel  = 2'd0;
        word_sel = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_out", out, 8'h00);
        check("arst_valid", out_valid, 1'b0);
        check("arst_ptr", ptr_out, 8'h00);
        check("arst_fault", fault, 1'b0);
        @(posedge clock);
        #1;
        check("arst_edge_v", out_valid, 1'b0);
        check("arst_edge_o", out, 8'h00);
        peek(2'd1);
        check("arst_p1", ptr_out, 8'h00);
        peek(2'd2);
        check("arst_p2", ptr_out, 8'h00);
        reset = 1'b1;

        // Memory content survives reset.
        do_op(READ, 2'd0, 1'b1, 8'h00);
        check("keep_3c", out, 8'h3C);
        do_op(LOAD, 2'd0, 1'b0, 8'h10);
        do_op(READ, 2'd0, 1'b0, 8'h00);
        check("keep_a5", out, 8'hA5);
        check("keep_valid", out_valid, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
